hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central pipeline controller for the 5-stage RV32 core (IF, DE, EX, MEM, WB).
- Sequences stall and flush for every stage.
- Generates operand-forwarding selects for the execute stage.
- Tracks multi-cycle data-memory accesses with a timeout.
- Sits beside the stages. Its outputs drive each stage's stall/flush inputs and the EX operand muxes.

Parameters:
AWIDTH, 5, register address width
MEM_TIMEOUT, 15, max MEM_WAIT cycles before abort (1..2^TWIDTH-1)
TWIDTH, 4, wait counter width

Ports:
h_clk  in  1  clock
h_rst  in  1  asynchronous active-low reset
h_i_de_ce  in  1  DE holds valid instr
h_i_de_addr_rs1/h_i_de_addr_rs2  in  AWIDTH each  DE source regs
h_i_ex_ce  in  1  EX holds valid instr
h_i_ex_addr_rs1/h_i_ex_addr_rs2  in  AWIDTH each  EX source regs
h_i_ex_addr_rd  in  AWIDTH  EX dest
h_i_ex_we  in  1  EX writes rd
h_i_ex_load  in  1  EX instr is load
h_i_mem_ce, h_i_mem_we  in  1 each  MEM valid / writes rd
h_i_mem_addr_rd  in  AWIDTH  MEM dest
h_i_wb_ce, h_i_wb_we  in  1 each  WB valid / writes rd
h_i_wb_addr_rd  in  AWIDTH  WB dest
h_i_change_pc  in  1  EX redirect (taken branch/jump)
h_i_mem_req  in  1  MEM issues data access this cycle
h_i_mem_ack  in  1  data memory completes
h_i_force_stall  in  1  external freeze
h_o_stall_if, h_o_stall_de, h_o_stall_ex, h_o_stall_mem  out  1 each  hold stage
h_o_flush_de, h_o_flush_ex  out  1 each  invalidate stage output (bubble)
h_o_fwd_rs1, h_o_fwd_rs2  out  2 each  00 regfile, 01 from MEM, 10 from WB
h_o_mem_timeout  out  1  one-cycle abort pulse
h_o_busy  out  1  FSM not IDLE

Behaviour:
- Reset (h_rst low, async): state IDLE, counter 0, h_o_mem_timeout 0. All stall/flush/fwd outputs evaluate to 0 while in reset.
- Stall/flush/fwd outputs are combinational from state + inputs, so they take effect in the same cycle. State, counter and h_o_mem_timeout are registered.
- FSM states:
  - IDLE, MEM_WAIT, REDIRECT.
  - IDLE -> MEM_WAIT when h_i_mem_req && !h_i_mem_ack; the counter loads 1.
  - MEM_WAIT: h_i_mem_ack -> IDLE, counter 0. Otherwise, when counter==MEM_TIMEOUT: h_o_mem_timeout=1 for the next cycle, go to IDLE. Otherwise counter+1.
  - IDLE -> REDIRECT on h_i_change_pc while not stalled by memory. REDIRECT lasts exactly 1 cycle, then IDLE.
- Memory stall: asserted in MEM_WAIT, or in IDLE when h_i_mem_req && !h_i_mem_ack. It drives all four stall outputs high.
- h_i_force_stall: all four stalls high. The FSM still advances on ack/timeout.
- Redirect: on the h_i_change_pc cycle, flush_de=1 and flush_ex=1. During REDIRECT, flush_de=1 only, covering the 1-cycle fetch latency.
- Load-use hazard: h_i_ex_ce && h_i_ex_load && h_i_ex_we && ex_rd!=0 && h_i_de_ce && (ex_rd==de_rs1 || ex_rd==de_rs2). Response: stall_if=1, stall_de=1, flush_ex=1 for one cycle (bubble).
- Priority: memory stall / force_stall > redirect > load-use. A lower-priority event is evaluated again next cycle, never dropped. Redirect raised during a memory stall is held by the EX stall and acted on at release.
- Forwarding, per rs of the EX instruction:
  - Select 01 if mem_ce && mem_we && mem_rd!=0 && mem_rd==rs.
  - Else 10 if the same conditions hold for WB.
  - Else 00.
  - MEM wins over WB. Register x0 never forwards.
- Reset asserted mid-MEM_WAIT aborts immediately: IDLE, no timeout pulse.

Optional Feature:
FORWARD_EN.
- Defined: forwarding as above; only load-use inserts a bubble.
- Undefined: h_o_fwd_rs1/rs2 tied 00. The RAW hazard check is extended to any valid writing EX, MEM or WB instruction whose rd (nonzero) matches de_rs1/rs2. Each matching cycle asserts stall_if, stall_de, flush_ex until the writer retires.

Test Plan:
1. Reset low mid-test with mem_req=1, no ack -> busy=0, all stalls 0, counter 0; release -> stall resumes same cycle.
2. mem_req=1, ack after 3 cycles -> all stalls high for 3 cycles, busy for 2 registered cycles, timeout never asserted.
3. mem_req=1, ack never -> exactly 15 stalled cycles after entry, h_o_mem_timeout=1 for one cycle, then IDLE.
4. EX load to x5, DE uses rs2=x5 -> one cycle of stall_if/stall_de/flush_ex; with rd=x0 -> no stall.
5. FORWARD_EN: MEM rd=x7, WB rd=x7, EX rs1=x7 -> fwd_rs1=01. MEM not writing -> 10. rs1=x0 -> 00.
6. change_pc=1 with simultaneous load-use -> flush_de+flush_ex, then 1 cycle flush_de, no load-use stall in the redirect cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing, EX operand-forwarding selects and data-memory
// wait tracking with timeout. Define FORWARD_EN to enable forwarding; otherwise RAW hazards stall.
module hazard_ctrl #(
  parameter int AWIDTH      = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int TWIDTH      = 4
) (
  input  logic              h_clk,
  input  logic              h_rst,
  input  logic              h_i_de_ce,
  input  logic [AWIDTH-1:0] h_i_de_addr_rs1,
  input  logic [AWIDTH-1:0] h_i_de_addr_rs2,
  input  logic              h_i_ex_ce,
  input  logic [AWIDTH-1:0] h_i_ex_addr_rs1,
  input  logic [AWIDTH-1:0] h_i_ex_addr_rs2,
  input  logic [AWIDTH-1:0] h_i_ex_addr_rd,
  input  logic              h_i_ex_we,
  input  logic              h_i_ex_load,
  input  logic              h_i_mem_ce,
  input  logic              h_i_mem_we,
  input  logic [AWIDTH-1:0] h_i_mem_addr_rd,
  input  logic              h_i_wb_ce,
  input  logic              h_i_wb_we,
  input  logic [AWIDTH-1:0] h_i_wb_addr_rd,
  input  logic              h_i_change_pc,
  input  logic              h_i_mem_req,
  input  logic              h_i_mem_ack,
  input  logic              h_i_force_stall,
  output logic              h_o_stall_if,
  output logic              h_o_stall_de,
  output logic              h_o_stall_ex,
  output logic              h_o_stall_mem,
  output logic              h_o_flush_de,
  output logic              h_o_flush_ex,
  output logic [1:0]        h_o_fwd_rs1,
  output logic [1:0]        h_o_fwd_rs2,
  output logic              h_o_mem_timeout,
  output logic              h_o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_REDIRECT} state_t;

  state_t            r_state, w_state_nxt;
  logic [TWIDTH-1:0] r_cnt, w_cnt_nxt;
  logic              r_mem_timeout, w_timeout_nxt;

  logic       w_mem_stall, w_hold, w_redirect_now;
  logic       w_ex_hit, w_mem_valid, w_wb_valid, w_hazard, w_raw;
  logic [1:0] w_fwd_rs1, w_fwd_rs2;

  assign w_mem_stall    = (r_state == S_MEM_WAIT) ||
                          (r_state == S_IDLE && h_i_mem_req && !h_i_mem_ack);
  assign w_hold         = w_mem_stall || h_i_force_stall;
  // A redirect seen while frozen stays in EX and is taken once the freeze lifts.
  assign w_redirect_now = (r_state == S_IDLE) && h_i_change_pc && !w_hold;

  assign w_ex_hit    = h_i_ex_ce && h_i_ex_we && (h_i_ex_addr_rd != '0) && h_i_de_ce &&
                       (h_i_ex_addr_rd == h_i_de_addr_rs1 || h_i_ex_addr_rd == h_i_de_addr_rs2);
  assign w_mem_valid = h_i_mem_ce && h_i_mem_we && (h_i_mem_addr_rd != '0);
  assign w_wb_valid  = h_i_wb_ce && h_i_wb_we && (h_i_wb_addr_rd != '0);

`ifdef FORWARD_EN
  assign w_hazard = w_ex_hit && h_i_ex_load;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_fwd_rs1 = 2'b00;
    w_fwd_rs2 = 2'b00;
    if (w_mem_valid && h_i_mem_addr_rd == h_i_ex_addr_rs1)     w_fwd_rs1 = 2'b01;
    else if (w_wb_valid && h_i_wb_addr_rd == h_i_ex_addr_rs1)  w_fwd_rs1 = 2'b10;
    if (w_mem_valid && h_i_mem_addr_rd == h_i_ex_addr_rs2)     w_fwd_rs2 = 2'b01;
    else if (w_wb_valid && h_i_wb_addr_rd == h_i_ex_addr_rs2)  w_fwd_rs2 = 2'b10;
  end
`else
  logic w_mem_hit, w_wb_hit, w_unused;

  assign w_mem_hit = w_mem_valid && h_i_de_ce &&
                     (h_i_mem_addr_rd == h_i_de_addr_rs1 || h_i_mem_addr_rd == h_i_de_addr_rs2);
  assign w_wb_hit  = w_wb_valid && h_i_de_ce &&
                     (h_i_wb_addr_rd == h_i_de_addr_rs1 || h_i_wb_addr_rd == h_i_de_addr_rs2);
  assign w_hazard  = w_ex_hit || w_mem_hit || w_wb_hit;
  assign w_fwd_rs1 = 2'b00;
  assign w_fwd_rs2 = 2'b00;
  assign w_unused  = ^{h_i_ex_load, h_i_ex_addr_rs1, h_i_ex_addr_rs2};
`endif

  // DE is being flushed during a redirect, so stalling it for a hazard would be pointless.
  assign w_raw = w_hazard && !w_hold && !w_redirect_now && (r_state != S_REDIRECT);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (h_i_mem_req && !h_i_mem_ack) begin
          w_state_nxt = S_MEM_WAIT;
          w_cnt_nxt   = TWIDTH'(1);
        end else if (w_redirect_now) begin
          w_state_nxt = S_REDIRECT;
        end
      end
      S_MEM_WAIT: begin
        if (h_i_mem_ack) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TWIDTH'(MEM_TIMEOUT)) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + TWIDTH'(1);
        end
      end
      S_REDIRECT: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge h_clk or negedge h_rst) begin
    if (!h_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  assign h_o_stall_if    = h_rst & (w_hold | w_raw);
  assign h_o_stall_de    = h_rst & (w_hold | w_raw);
  assign h_o_stall_ex    = h_rst & w_hold;
  assign h_o_stall_mem   = h_rst & w_hold;
  assign h_o_flush_de    = h_rst & (w_redirect_now | (r_state == S_REDIRECT));
  assign h_o_flush_ex    = h_rst & (w_redirect_now | w_raw);
  assign h_o_fwd_rs1     = h_rst ? w_fwd_rs1 : 2'b00;
  assign h_o_fwd_rs2     = h_rst ? w_fwd_rs2 : 2'b00;
  assign h_o_mem_timeout = r_mem_timeout;
  assign h_o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: table of combinational hazard/forwarding
// vectors plus hand-written sequences for memory wait, timeout, reset abort and redirect.
module tb_hazard_ctrl;

  logic       h_clk, h_rst;
  logic       h_i_de_ce;
  logic [4:0] h_i_de_addr_rs1, h_i_de_addr_rs2;
  logic       h_i_ex_ce;
  logic [4:0] h_i_ex_addr_rs1, h_i_ex_addr_rs2, h_i_ex_addr_rd;
  logic       h_i_ex_we, h_i_ex_load;
  logic       h_i_mem_ce, h_i_mem_we;
  logic [4:0] h_i_mem_addr_rd;
  logic       h_i_wb_ce, h_i_wb_we;
  logic [4:0] h_i_wb_addr_rd;
  logic       h_i_change_pc, h_i_mem_req, h_i_mem_ack, h_i_force_stall;
  logic       h_o_stall_if, h_o_stall_de, h_o_stall_ex, h_o_stall_mem;
  logic       h_o_flush_de, h_o_flush_ex;
  logic [1:0] h_o_fwd_rs1, h_o_fwd_rs2;
  logic       h_o_mem_timeout, h_o_busy;

  // {stall_if, stall_de, stall_ex, stall_mem, flush_de, flush_ex, fwd_rs1, fwd_rs2}
  logic [9:0] w_out;
  assign w_out = {h_o_stall_if, h_o_stall_de, h_o_stall_ex, h_o_stall_mem,
                  h_o_flush_de, h_o_flush_ex, h_o_fwd_rs1, h_o_fwd_rs2};

  int n_pass  = 0;
  int n_total = 0;

  hazard_ctrl dut (
    .h_clk(h_clk), .h_rst(h_rst),
    .h_i_de_ce(h_i_de_ce), .h_i_de_addr_rs1(h_i_de_addr_rs1), .h_i_de_addr_rs2(h_i_de_addr_rs2),
    .h_i_ex_ce(h_i_ex_ce), .h_i_ex_addr_rs1(h_i_ex_addr_rs1), .h_i_ex_addr_rs2(h_i_ex_addr_rs2),
    .h_i_ex_addr_rd(h_i_ex_addr_rd), .h_i_ex_we(h_i_ex_we), .h_i_ex_load(h_i_ex_load),
    .h_i_mem_ce(h_i_mem_ce), .h_i_mem_we(h_i_mem_we), .h_i_mem_addr_rd(h_i_mem_addr_rd),
    .h_i_wb_ce(h_i_wb_ce), .h_i_wb_we(h_i_wb_we), .h_i_wb_addr_rd(h_i_wb_addr_rd),
    .h_i_change_pc(h_i_change_pc), .h_i_mem_req(h_i_mem_req), .h_i_mem_ack(h_i_mem_ack),
    .h_i_force_stall(h_i_force_stall),
    .h_o_stall_if(h_o_stall_if), .h_o_stall_de(h_o_stall_de),
    .h_o_stall_ex(h_o_stall_ex), .h_o_stall_mem(h_o_stall_mem),
    .h_o_flush_de(h_o_flush_de), .h_o_flush_ex(h_o_flush_ex),
    .h_o_fwd_rs1(h_o_fwd_rs1), .h_o_fwd_rs2(h_o_fwd_rs2),
    .h_o_mem_timeout(h_o_mem_timeout), .h_o_busy(h_o_busy)
  );

  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  typedef struct {
    logic       de_ce;
    logic [4:0] de_rs1, de_rs2;
    logic       ex_ce, ex_we, ex_load;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mem_ce, mem_we;
    logic [4:0] mem_rd;
    logic       wb_ce, wb_we;
    logic [4:0] wb_rd;
    logic       force_stall;
    logic [9:0] exp_fe;
    logic [9:0] exp_nf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge h_clk);
    #1;
  endtask

  task automatic clear_inputs();
    h_i_de_ce = 0; h_i_de_addr_rs1 = 0; h_i_de_addr_rs2 = 0;
    h_i_ex_ce = 0; h_i_ex_addr_rs1 = 0; h_i_ex_addr_rs2 = 0; h_i_ex_addr_rd = 0;
    h_i_ex_we = 0; h_i_ex_load = 0;
    h_i_mem_ce = 0; h_i_mem_we = 0; h_i_mem_addr_rd = 0;
    h_i_wb_ce = 0; h_i_wb_we = 0; h_i_wb_addr_rd = 0;
    h_i_change_pc = 0; h_i_mem_req = 0; h_i_mem_ack = 0; h_i_force_stall = 0;
  endtask

  task automatic set_load_use();
    h_i_de_ce = 1; h_i_de_addr_rs1 = 5'd5;
    h_i_ex_ce = 1; h_i_ex_we = 1; h_i_ex_load = 1; h_i_ex_addr_rd = 5'd5;
  endtask

  // Entered at posedge+1 with mem_req held high; returns at the timeout cycle.
  task automatic run_to_timeout(input string tag);
    int n_busy = 0;
    int n_free = 0;
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      #1;
      if (h_o_mem_timeout) seen = 1;
      else begin
        if (h_o_busy) n_busy++;
        if (!h_o_stall_mem) n_free++;
        tick();
      end
    end
    check({tag, "_timeout_seen"}, 16'(seen), 16'd1);
    check({tag, "_wait_cycles"}, 16'(n_busy), 16'd15);
    check({tag, "_unstalled_cycles"}, 16'(n_free), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000000000, 10'b0000000000};
    vecs[1]  = '{1, 3, 5, 1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 10'b1100010000, 10'b1100010000};
    vecs[2]  = '{1, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000000000, 10'b0000000000};
    vecs[3]  = '{0, 3, 5, 1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 10'b0000000000, 10'b0000000000};
    vecs[4]  = '{1, 5, 2, 1, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 10'b0000000000, 10'b1100010000};
    vecs[5]  = '{0, 0, 0, 1, 0, 0, 7, 0, 0, 1, 1, 7, 1, 1, 7, 0, 10'b0000000100, 10'b0000000000};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 7, 0, 0, 1, 0, 7, 1, 1, 7, 0, 10'b0000001000, 10'b0000000000};
    vecs[7]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 10'b0000000000, 10'b0000000000};
    vecs[8]  = '{1, 9, 0, 1, 0, 0, 0, 9, 0, 0, 1, 9, 1, 1, 9, 0, 10'b0000000010, 10'b1100010000};
    vecs[9]  = '{1, 0, 4, 1, 0, 0, 0, 4, 0, 1, 1, 4, 0, 0, 0, 0, 10'b0000000001, 10'b1100010000};
    vecs[10] = '{1, 5, 0, 1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 10'b1111000000, 10'b1111000000};
    vecs[11] = '{1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 10'b0000000000, 10'b0000000000};
    vecs[12] = '{0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 1, 3, 0, 0, 0, 1, 10'b1111000100, 10'b1111000000};

    // Reset state, with a pending memory request that must not stall.
    clear_inputs();
    h_rst = 0;
    h_i_mem_req = 1;
    #2;
    check("reset_outputs", 16'(w_out), 16'd0);
    check("reset_busy", 16'(h_o_busy), 16'd0);
    check("reset_timeout", 16'(h_o_mem_timeout), 16'd0);
    tick();
    h_i_mem_req = 0;
    h_rst = 1;
    tick();

    // Combinational hazard / forwarding table.
    for (int i = 0; i < 13; i++) begin
      clear_inputs();
      h_i_de_ce = vecs[i].de_ce; h_i_de_addr_rs1 = vecs[i].de_rs1; h_i_de_addr_rs2 = vecs[i].de_rs2;
      h_i_ex_ce = vecs[i].ex_ce; h_i_ex_we = vecs[i].ex_we; h_i_ex_load = vecs[i].ex_load;
      h_i_ex_addr_rs1 = vecs[i].ex_rs1; h_i_ex_addr_rs2 = vecs[i].ex_rs2;
      h_i_ex_addr_rd = vecs[i].ex_rd;
      h_i_mem_ce = vecs[i].mem_ce; h_i_mem_we = vecs[i].mem_we; h_i_mem_addr_rd = vecs[i].mem_rd;
      h_i_wb_ce = vecs[i].wb_ce; h_i_wb_we = vecs[i].wb_we; h_i_wb_addr_rd = vecs[i].wb_rd;
      h_i_force_stall = vecs[i].force_stall;
      #1;
`ifdef FORWARD_EN
      check($sformatf("vec%0d", i), 16'(w_out), 16'(vecs[i].exp_fe));
`else
      check($sformatf("vec%0d", i), 16'(w_out), 16'(vecs[i].exp_nf));
`endif
      tick();
    end

    // Memory access acknowledged on the third cycle.
    clear_inputs();
    h_i_mem_req = 1;
    #1;
    check("ack3_c0_out", 16'(w_out), 16'h3C0);
    check("ack3_c0_busy", 16'(h_o_busy), 16'd0);
    tick();
    #1;
    check("ack3_c1_out", 16'(w_out), 16'h3C0);
    check("ack3_c1_busy", 16'(h_o_busy), 16'd1);
    tick();
    h_i_mem_ack = 1;
    #1;
    check("ack3_c2_out", 16'(w_out), 16'h3C0);
    check("ack3_c2_busy", 16'(h_o_busy), 16'd1);
    tick();
    h_i_mem_req = 0;
    h_i_mem_ack = 0;
    #1;
    check("ack3_c3_out", 16'(w_out), 16'd0);
    check("ack3_c3_busy", 16'(h_o_busy), 16'd0);
    check("ack3_c3_timeout", 16'(h_o_mem_timeout), 16'd0);
    tick();

    // Memory access never acknowledged: abort after 15 wait cycles.
    h_i_mem_req = 1;
    run_to_timeout("to");
    h_i_mem_req = 0;
    #1;
    check("to_pulse_out", 16'(w_out), 16'd0);
    check("to_pulse_busy", 16'(h_o_busy), 16'd0);
    tick();
    #1;
    check("to_pulse_width", 16'(h_o_mem_timeout), 16'd0);
    tick();

    // Reset in the middle of a wait aborts it; on release the stall resumes at once.
    h_i_mem_req = 1;
    tick(); tick(); tick(); tick();
    h_rst = 0;
    #1;
    check("rst_mid_out", 16'(w_out), 16'd0);
    check("rst_mid_busy", 16'(h_o_busy), 16'd0);
    tick();
    #1;
    check("rst_hold_out", 16'(w_out), 16'd0);
    check("rst_hold_timeout", 16'(h_o_mem_timeout), 16'd0);
    h_rst = 1;
    #1;
    check("rst_release_out", 16'(w_out), 16'h3C0);
    tick();
    run_to_timeout("rst");
    h_i_mem_req = 0;
    tick();
    tick();

    // Redirect together with a load-use hazard.
    clear_inputs();
    set_load_use();
    h_i_change_pc = 1;
    #1;
    check("redir_c0_out", 16'(w_out), 16'h030);
    tick();
    h_i_change_pc = 0;
    #1;
    check("redir_c1_out", 16'(w_out), 16'h020);
    check("redir_c1_busy", 16'(h_o_busy), 16'd1);
    tick();
    #1;
    check("redir_c2_loaduse", 16'(w_out), 16'h310);
    check("redir_c2_busy", 16'(h_o_busy), 16'd0);
    tick();

    // Redirect raised during a memory stall is held, then acted on at release.
    clear_inputs();
    h_i_mem_req = 1;
    h_i_change_pc = 1;
    #1;
    check("held_c0_out", 16'(w_out), 16'h3C0);
    tick();
    h_i_mem_ack = 1;
    #1;
    check("held_c1_out", 16'(w_out), 16'h3C0);
    tick();
    h_i_mem_req = 0;
    h_i_mem_ack = 0;
    #1;
    check("held_c2_out", 16'(w_out), 16'h030);
    tick();
    h_i_change_pc = 0;
    #1;
    check("held_c3_out", 16'(w_out), 16'h020);
    tick();
    #1;
    check("held_c4_busy", 16'(h_o_busy), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
